// File: rtl/hex_display_mux_if.sv
// Pin bundle between a data source and the 7-segment scanner.
// Inputs flow master -> slave, display pins flow slave -> master.
interface hex_display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic                  lz_en;
  logic [3:0]            brightness;
  logic [N_DIGITS-1:0]   anodes;
  logic [7:0]            seg;
  logic                  frame_start;

  modport master (
    output data, dp, blank,
    output lz_en, brightness,
    input  anodes, seg, frame_start
  );

  modport slave (
    input  data, dp, blank,
    input  lz_en, brightness,
    output anodes, seg, frame_start
  );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed 7-segment scanner with frame latching,
// leading-zero blanking, PWM dimming and anti-ghost gaps.
module hex_display_mux #(
  parameter int N_DIGITS         = 4,
  parameter int DIV              = 5000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input logic               clk,
  input logic               rst,
  hex_display_mux_if.slave  bus
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] AN_OFF =
    {N_DIGITS{ANODE_ACTIVE_LOW != 0}};
  localparam logic [7:0] SEG_OFF =
    {8{SEG_ACTIVE_LOW != 0}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            pwm;
  logic [4*N_DIGITS-1:0] data_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [N_DIGITS-1:0]   blank_q;
  logic                  lz_q;
  logic [N_DIGITS-1:0]   anodes_q;
  logic [7:0]            seg_q;
  logic                  fs_q;

  logic                  frame_begin;
  logic [4*N_DIGITS-1:0] data_e;
  logic [N_DIGITS-1:0]   dp_e;
  logic [N_DIGITS-1:0]   blank_e;
  logic                  lz_e;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic                  suppressed;
  logic                  lit;
  logic [N_DIGITS-1:0]   onehot;

  function automatic logic [6:0] glyph(
    input logic [3:0] v
  );
    logic [6:0] g;
    g = '0;
    unique case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

  // During the first cycle of a frame the live inputs are shown
  // directly, so the whole frame uses the word latched there.
  always_comb begin
    frame_begin = (cnt == '0) && (idx == '0);
    data_e  = frame_begin ? bus.data  : data_q;
    dp_e    = frame_begin ? bus.dp    : dp_q;
    blank_e = frame_begin ? bus.blank : blank_q;
    lz_e    = frame_begin ? bus.lz_en : lz_q;
  end

  // Current nibble, leading-zero test and visibility decision.
  always_comb begin
    nib      = '0;
    upper_nz = 1'b0;
    onehot   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IW'(k) == idx)
        nib = data_e[4*k +: 4];
      if (IW'(k) >= idx && data_e[4*k +: 4] != 4'h0)
        upper_nz = 1'b1;
      onehot[k] = (IW'(k) == idx);
    end
    suppressed = lz_e && (idx != '0) && !upper_nz;
    lit = (cnt >= CNT_BLANK) && !blank_e[idx] &&
          !suppressed &&
          (bus.brightness == 4'hF ||
           pwm < bus.brightness);
  end

  // Slot counter, digit index and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + 4'd1;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Frame-coherent capture of the display word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      lz_q    <= 1'b0;
    end else if (frame_begin) begin
      data_q  <= bus.data;
      dp_q    <= bus.dp;
      blank_q <= bus.blank;
      lz_q    <= bus.lz_en;
    end
  end

  // Anodes and segments share one register stage, polarity last.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodes_q <= AN_OFF;
      seg_q    <= SEG_OFF;
      fs_q     <= 1'b0;
    end else begin
      anodes_q <= (lit ? onehot : '0) ^ AN_OFF;
      seg_q    <= (lit ? {dp_e[idx], glyph(nib)}
                       : 8'h00) ^ SEG_OFF;
      fs_q     <= frame_begin;
    end
  end

  assign bus.anodes      = anodes_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: three parameter sets driven
// in lockstep and checked against a cycle-count model.
module tb_hex_display_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [3:0]  brightness;

  always #5 clk = ~clk;

  hex_display_mux_if #(.N_DIGITS(4)) b0 ();
  hex_display_mux_if #(.N_DIGITS(4)) b1 ();
  hex_display_mux_if #(.N_DIGITS(4)) b2 ();

  assign b0.data = data;
  assign b0.dp = dp;
  assign b0.blank = blank;
  assign b0.lz_en = lz_en;
  assign b0.brightness = brightness;
  assign b1.data = data;
  assign b1.dp = dp;
  assign b1.blank = blank;
  assign b1.lz_en = lz_en;
  assign b1.brightness = brightness;
  assign b2.data = data;
  assign b2.dp = dp;
  assign b2.blank = blank;
  assign b2.lz_en = lz_en;
  assign b2.brightness = brightness;

  hex_display_mux #(
    .N_DIGITS(4), .DIV(8), .BLANK_CYCLES(2),
    .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) u0 (.clk(clk), .rst(rst), .bus(b0.slave));

  hex_display_mux #(
    .N_DIGITS(4), .DIV(64), .BLANK_CYCLES(0),
    .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  hex_display_mux #(
    .N_DIGITS(4), .DIV(8), .BLANK_CYCLES(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

  // {anodes[3:0], seg[7:0], frame_start}
  logic [12:0] o0, o1, o2;
  assign o0 = {b0.anodes, b0.seg, b0.frame_start};
  assign o1 = {b1.anodes, b1.seg, b1.frame_start};
  assign o2 = {b2.anodes, b2.seg, b2.frame_start};

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
  } snap_t;

  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [12:0] OFF_INV = {4'hF, 8'hFF, 1'b0};

  int    t;
  snap_t s0, s1;
  logic [12:0] e0, e1, e2;
  int    tests = 0;
  int    fails = 0;

  // Expected pins for state number t since reset.
  function automatic logic [12:0] model(
    input int t_in, input int div, input int blank_c,
    input snap_t s, input logic [3:0] br
  );
    int cnt, idx, pwm;
    logic [15:0] hi;
    logic sup, vis;
    logic [3:0] an;
    logic [7:0] sg;
    cnt = t_in % div;
    idx = (t_in / div) % 4;
    pwm = t_in % 16;
    hi  = s.d >> (4 * idx);
    sup = s.lz && idx != 0 && hi == 16'h0;
    vis = cnt >= blank_c && !s.bl[idx] && !sup &&
          (br == 4'hF || pwm < int'(br));
    an  = vis ? 4'(1 << idx) : 4'h0;
    sg  = vis ? {s.dp[idx], GLYPH[hi[3:0]][6:0]} : 8'h00;
    return {an, sg, (cnt == 0 && idx == 0)};
  endfunction

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      e0 = '0;
      e1 = '0;
      e2 = OFF_INV;
      t  = 0;
    end else begin
      if (t % 32 == 0)
        s0 = '{data, dp, blank, lz_en};
      if (t % 256 == 0)
        s1 = '{data, dp, blank, lz_en};
      e0 = model(t, 8, 2, s0, brightness);
      e1 = model(t, 64, 0, s1, brightness);
      e2 = {~e0[12:1], e0[0]};
      t++;
    end
    #1;
  endtask

  task automatic set_in(
    input logic [15:0] d, input logic [3:0] p,
    input logic [3:0] b, input logic z,
    input logic [3:0] br
  );
    data = d;
    dp = p;
    blank = b;
    lz_en = z;
    brightness = br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    advance();
    advance();
    tests++;
    if (o0 !== 13'h0) begin
      fails++;
      $display("FAIL reset u0: got %h want %h", o0, 13'h0);
    end
    tests++;
    if (o1 !== 13'h0) begin
      fails++;
      $display("FAIL reset u1: got %h want %h", o1, 13'h0);
    end
    tests++;
    if (o2 !== OFF_INV) begin
      fails++;
      $display("FAIL reset u2: got %h want %h", o2, OFF_INV);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [7:0] tab [4] = '{8'h71, 8'h77, 8'h5B, 8'h06};
    logic [12:0] ex;
    int tt, c, i, nfs;
    nfs = 0;
    set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF);
    do_reset();
    for (int k = 0; k < 64; k++) begin
      advance();
      tt = t - 1;
      c = tt % 8;
      i = (tt / 8) % 4;
      ex = (c >= 2) ? {4'(1 << i), tab[i], 1'b0} : 13'h0;
      ex[0] = (tt % 32 == 0);
      if (o0[0]) nfs++;
      tests++;
      if (o0 !== ex) begin
        fails++;
        $display("FAIL scan t=%0d: got %h want %h", tt, o0, ex);
      end
    end
    tests++;
    if (nfs != 2) begin
      fails++;
      $display("FAIL scan_fs_count: got %0d want 2", nfs);
    end
  endtask

  task automatic test_lz();
    logic [3:0] seen;
    for (int pass = 0; pass < 2; pass++) begin
      seen = 4'h0;
      set_in(pass == 0 ? 16'h0030 : 16'h0000,
             4'h0, 4'h0, 1'b1, 4'hF);
      do_reset();
      for (int k = 0; k < 32; k++) begin
        advance();
        seen |= o0[12:9];
        tests++;
        if (o0 !== e0) begin
          fails++;
          $display("FAIL lz t=%0d: got %h want %h",
                   t - 1, o0, e0);
        end
        if (o0[12:9] == 4'b0010) begin
          tests++;
          if (o0[8:1] !== 8'h4F) begin
            fails++;
            $display("FAIL lz_d1: got %h want 4f", o0[8:1]);
          end
        end
        if (o0[12:9] == 4'b0001) begin
          tests++;
          if (o0[8:1] !== 8'h3F) begin
            fails++;
            $display("FAIL lz_d0: got %h want 3f", o0[8:1]);
          end
        end
      end
      tests++;
      if (seen !== (pass == 0 ? 4'b0011 : 4'b0001)) begin
        fails++;
        $display("FAIL lz_seen pass=%0d: got %b", pass, seen);
      end
    end
  endtask

  task automatic test_latch();
    set_in(16'h1111, 4'h0, 4'h0, 1'b0, 4'hF);
    do_reset();
    for (int k = 0; k < 64; k++) begin
      if (k == 18) data = 16'h2222;
      advance();
      tests++;
      if (o0 !== e0) begin
        fails++;
        $display("FAIL latch t=%0d: got %h want %h",
                 t - 1, o0, e0);
      end
      if (o0[12:9] != 4'h0) begin
        tests++;
        if (o0[8:1] !== (k < 32 ? 8'h06 : 8'h5B)) begin
          fails++;
          $display("FAIL latch_seg t=%0d: got %h", t - 1,
                   o0[8:1]);
        end
      end
    end
  endtask

  task automatic test_pwm();
    int lit;
    lit = 0;
    set_in(16'h1234, 4'h0, 4'h0, 1'b0, 4'h4);
    do_reset();
    for (int k = 0; k < 64; k++) begin
      advance();
      tests++;
      if (o1 !== e1) begin
        fails++;
        $display("FAIL pwm t=%0d: got %h want %h",
                 t - 1, o1, e1);
      end
      if (o1[12:9] != 4'h0) begin
        lit++;
        tests++;
        if ((t - 1) % 16 >= 4) begin
          fails++;
          $display("FAIL pwm_phase: lit at t=%0d", t - 1);
        end
      end
    end
    tests++;
    if (lit != 16) begin
      fails++;
      $display("FAIL pwm_duty: got %0d want 16", lit);
    end
    brightness = 4'h0;
    lit = 0;
    for (int k = 0; k < 64; k++) begin
      advance();
      if (o1[12:9] != 4'h0 || o0[12:9] != 4'h0) lit++;
    end
    tests++;
    if (lit != 0) begin
      fails++;
      $display("FAIL pwm_off: got %0d lit want 0", lit);
    end
  endtask

  task automatic test_dp_blank();
    set_in(16'h4321, 4'b0100, 4'b0001, 1'b0, 4'hF);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      advance();
      tests++;
      if (o0 !== e0 || o2 !== e2) begin
        fails++;
        $display("FAIL dpb t=%0d: got %h/%h want %h/%h",
                 t - 1, o0, o2, e0, e2);
      end
      tests++;
      if (o0[9] !== 1'b0 || o2[9] !== 1'b1) begin
        fails++;
        $display("FAIL dpb_an0: got %b/%b want 0/1",
                 o0[9], o2[9]);
      end
      if (o0[12:9] == 4'b0100) begin
        tests++;
        if (o0[8] !== 1'b1 || o2[8] !== 1'b0) begin
          fails++;
          $display("FAIL dpb_dp: got %b/%b want 1/0",
                   o0[8], o2[8]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] lit0;
    lit0 = {4'b0001, 8'h6D, 1'b0};
    set_in(16'h0005, 4'h0, 4'h0, 1'b0, 4'hF);
    do_reset();
    repeat (27) advance();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    tests++;
    if (o0 !== 13'h0 || o2 !== OFF_INV) begin
      fails++;
      $display("FAIL rstmid: got %h/%h want 0/%h",
               o0, o2, OFF_INV);
    end
    advance();
    tests++;
    if (o0 !== 13'h1) begin
      fails++;
      $display("FAIL rstmid_fs: got %h want 0001", o0);
    end
    advance();
    tests++;
    if (o0 !== 13'h0) begin
      fails++;
      $display("FAIL rstmid_gap: got %h want 0000", o0);
    end
    advance();
    tests++;
    if (o0 !== lit0) begin
      fails++;
      $display("FAIL rstmid_lit: got %h want %h", o0, lit0);
    end
  endtask

  task automatic rand_in();
    for (int k = 0; k < 4; k++)
      data[4*k +: 4] = ($urandom_range(0, 1) == 1) ?
                       4'($urandom) : 4'h0;
    dp = 4'($urandom);
    blank = ($urandom_range(0, 3) == 0) ?
            4'($urandom) : 4'h0;
    lz_en = 1'($urandom);
    brightness = ($urandom_range(0, 2) == 0) ?
                 4'hF : 4'($urandom);
  endtask

  task automatic test_random();
    rand_in();
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) rand_in();
      rst = ($urandom_range(0, 599) == 0);
      advance();
      tests++;
      if (o0 !== e0 || o1 !== e1 || o2 !== e2) begin
        fails++;
        $display("FAIL rand t=%0d: got %h/%h/%h want %h/%h/%h",
                 t - 1, o0, o1, o2, e0, e1, e2);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    t = 0;
    s0 = '0;
    s1 = '0;
    set_in(16'h0, 4'h0, 4'h0, 1'b0, 4'hF);
    test_reset();
    test_scan();
    test_lz();
    test_latch();
    test_pwm();
    test_dp_blank();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
